// File: rtl/ula_seq.sv
// ula_seq: multi-cycle MIPS EX-stage ALU behind a valid/ready handshake.
// Single-cycle ops complete one cycle after acceptance; MUL (shift-add) and
// DIV (restoring) iterate one bit per cycle for WIDTH cycles.
// Optional macro ULA_SEQ_REM_EN adds the rem_out port carrying the DIV remainder.
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [3:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Zero_flag,
    output logic             Ovf_flag,
    output logic             Dz_flag,
    output logic             busy
`ifdef ULA_SEQ_REM_EN
    ,
    output logic [WIDTH-1:0] rem_out
`endif
);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIV  = 4'b1101;
    localparam logic [3:0] OP_INC  = 4'b1110;
    localparam logic [3:0] OP_DEC  = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t                  state;
    logic [SHW-1:0]          cnt;
    // acc: partial product (MUL) or partial remainder (DIV)
    // op_a: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
    // op_b: multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        op_a;
    logic [WIDTH-1:0]        op_b;

    logic                    accept;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          shamt;

    logic [WIDTH-1:0]        mul_acc_nx;
    logic [WIDTH:0]          div_sh;
    logic [WIDTH:0]          div_diff;
    logic [WIDTH-1:0]        div_rem_nx;
    logic [WIDTH-1:0]        div_quo_nx;
    logic                    last_iter;

`ifndef ULA_SEQ_REM_EN
    logic [WIDTH-1:0]        rem_unused;
`endif

    // Signed overflow of a two's-complement add given operand and result signs
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign a_s       = $signed(In1);
    assign b_s       = $signed(In2);
    assign shamt     = In2[SHW-1:0];
    assign last_iter = (cnt == SHW'(WIDTH - 1));

    // Single-cycle result and overflow for the opcode currently presented
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (OP)
            OP_ADD: begin
                alu_res = In1 + In2;
                alu_ovf = add_ovf(In1[WIDTH-1], In2[WIDTH-1], alu_res[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = In1 - In2;
                alu_ovf = add_ovf(In1[WIDTH-1], ~In2[WIDTH-1], alu_res[WIDTH-1]);
            end
            OP_AND:  alu_res = In1 & In2;
            OP_OR:   alu_res = In1 | In2;
            OP_XOR:  alu_res = In1 ^ In2;
            OP_NOT:  alu_res = ~In1;
            OP_SLL:  alu_res = In1 << shamt;
            OP_SRL:  alu_res = In1 >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
            OP_INC: begin
                alu_res = In1 + 1'b1;
                alu_ovf = add_ovf(In1[WIDTH-1], 1'b0, alu_res[WIDTH-1]);
            end
            OP_DEC: begin
                alu_res = In1 - 1'b1;
                alu_ovf = add_ovf(In1[WIDTH-1], 1'b1, alu_res[WIDTH-1]);
            end
            default: alu_res = '0;  // NOP, MUL and DIV-by-zero all yield 0 here
        endcase
    end

    // Next values of one shift-add multiply step and one restoring divide step
    always_comb begin
        mul_acc_nx = acc + (op_b[0] ? op_a : '0);
        div_sh     = {acc, op_a[WIDTH-1]};
        div_diff   = div_sh - {1'b0, op_b};
        if (div_diff[WIDTH]) begin
            div_rem_nx = div_sh[WIDTH-1:0];
            div_quo_nx = {op_a[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_nx = div_diff[WIDTH-1:0];
            div_quo_nx = {op_a[WIDTH-2:0], 1'b1};
        end
    end

`ifndef ULA_SEQ_REM_EN
    assign rem_unused = div_rem_nx;
`endif

    // Control FSM with registered result, flags and handshake state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            Zero_flag <= 1'b0;
            Ovf_flag  <= 1'b0;
            Dz_flag   <= 1'b0;
            out_valid <= 1'b0;
`ifdef ULA_SEQ_REM_EN
            rem_out   <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (OP == OP_MUL) begin
                            state <= MUL;
                            cnt   <= '0;
                            acc   <= '0;
                            op_a  <= In1;
                            op_b  <= In2;
                        end else if (OP == OP_DIV && In2 != '0) begin
                            state <= DIV;
                            cnt   <= '0;
                            acc   <= '0;
                            op_a  <= In1;
                            op_b  <= In2;
                        end else begin
                            result    <= alu_res;
                            Zero_flag <= (alu_res == '0);
                            Ovf_flag  <= alu_ovf;
                            Dz_flag   <= (OP == OP_DIV);
                            out_valid <= 1'b1;
`ifdef ULA_SEQ_REM_EN
                            rem_out   <= (OP == OP_DIV) ? In1 : '0;
`endif
                        end
                    end
                end
                MUL: begin
                    acc  <= mul_acc_nx;
                    op_a <= {op_a[WIDTH-2:0], 1'b0};
                    op_b <= {1'b0, op_b[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        state     <= IDLE;
                        result    <= mul_acc_nx;
                        Zero_flag <= (mul_acc_nx == '0);
                        Ovf_flag  <= 1'b0;
                        Dz_flag   <= 1'b0;
                        out_valid <= 1'b1;
`ifdef ULA_SEQ_REM_EN
                        rem_out   <= '0;
`endif
                    end
                end
                DIV: begin
                    acc  <= div_rem_nx;
                    op_a <= div_quo_nx;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        state     <= IDLE;
                        result    <= div_quo_nx;
                        Zero_flag <= (div_quo_nx == '0);
                        Ovf_flag  <= 1'b0;
                        Dz_flag   <= 1'b0;
                        out_valid <= 1'b1;
`ifdef ULA_SEQ_REM_EN
                        rem_out   <= div_rem_nx;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=32) with hand-computed expected values.
module tb_ula_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] In1 = '0;
    logic [31:0] In2 = '0;
    logic [3:0]  OP = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        Zero_flag;
    logic        Ovf_flag;
    logic        Dz_flag;
    logic        busy;
`ifdef ULA_SEQ_REM_EN
    logic [31:0] rem_out;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ula_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In1       (In1),
        .In2       (In2),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Zero_flag (Zero_flag),
        .Ovf_flag  (Ovf_flag),
        .Dz_flag   (Dz_flag),
        .busy      (busy)
`ifdef ULA_SEQ_REM_EN
        ,
        .rem_out   (rem_out)
`endif
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op for one clock; returns at the falling edge after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        OP = op; In1 = a; In2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        In1 = 32'hDEAD_BEEF; In2 = 32'h0BAD_F00D; OP = 4'b0000;
    endtask

    // Wait for out_valid after an iterative op, checking busy/in_ready on the way
    task automatic wait_iter(input string tag);
        int cyc = 0;
        int bad = 0;
        while (!out_valid && cyc < 100) begin
            if (!busy || in_ready) bad++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 32);
        chk({tag, "_busy_rdy"}, bad, 0);
    endtask

    initial begin
        int bad;
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'b0, Zero_flag, Ovf_flag, Dz_flag}, 32'h0);
        chk("rst_valid_busy", {30'b0, out_valid, busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0001, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_res", result, 32'h8000_0000);
        chk("add_flags", {29'b0, Zero_flag, Ovf_flag, out_valid}, 32'h3);

        issue(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("slt_res", result, 32'h1);
        chk("slt_valid", {31'b0, out_valid}, 32'h1);
        issue(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("sltu_res", result, 32'h0);
        chk("sltu_zero", {31'b0, Zero_flag}, 32'h1);
        issue(4'b1001, 32'h8000_0000, 32'h0000_0024);
        chk("sra_res", result, 32'hF800_0000);
        issue(4'b0010, 32'h8000_0000, 32'h0000_0001);
        chk("sub_ovf_res", result, 32'h7FFF_FFFF);
        chk("sub_ovf_flag", {31'b0, Ovf_flag}, 32'h1);
        issue(4'b1111, 32'h0000_0000, 32'h0);
        chk("dec_res", result, 32'hFFFF_FFFF);
        chk("dec_ovf", {31'b0, Ovf_flag}, 32'h0);
        issue(4'b0111, 32'h0000_0003, 32'h0000_0021);
        chk("sll_res", result, 32'h0000_0006);

        issue(4'b1100, 32'h0001_2345, 32'h0000_0010);
        wait_iter("mul");
        chk("mul_res", result, 32'h0012_3450);
        chk("mul_busy_end", {31'b0, busy}, 32'h0);

        issue(4'b1101, 32'd100, 32'd7);
        wait_iter("div");
        chk("div_res", result, 32'd14);
        chk("div_dz", {31'b0, Dz_flag}, 32'h0);
`ifdef ULA_SEQ_REM_EN
        chk("div_rem", rem_out, 32'd2);
`endif

        issue(4'b1101, 32'd5, 32'd0);
        chk("dz_res", result, 32'h0);
        chk("dz_flags", {29'b0, Zero_flag, Dz_flag, busy}, 32'h6);
`ifdef ULA_SEQ_REM_EN
        chk("dz_rem", rem_out, 32'd5);
`endif

        issue(4'b0001, 32'd2, 32'd3);
        chk("bp_add_res", result, 32'd5);
        out_ready = 1'b0;
        OP = 4'b0001; In1 = 32'd9; In2 = 32'd9; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== 32'd5 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("bp_hold", bad, 0);
        out_ready = 1'b1;
        issue(4'b0010, 32'd3, 32'd5);
        chk("bp_sub_res", result, 32'hFFFF_FFFE);
        chk("bp_sub_valid", {30'b0, out_valid, Ovf_flag}, 32'h2);
        @(negedge clk);
        chk("consume_clear", {31'b0, out_valid}, 32'h0);
        chk("consume_hold", result, 32'hFFFF_FFFE);

        issue(4'b1101, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        chk("rstdiv_busy_pre", {31'b0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res", result, 32'h0);
        chk("arst_ctl", {29'b0, out_valid, busy, Dz_flag}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_out", {30'b0, out_valid, busy}, 32'h0);
        issue(4'b0001, 32'd2, 32'd2);
        chk("post_rst_add", result, 32'd4);
        chk("post_rst_valid", {31'b0, out_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
